// File: rtl/imem_boot_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words, writes them to the
// instruction memory from address 0, and releases the core reset once the program is in.
`timescale 1ns/1ps
module imem_boot_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t            state;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] word_cnt;
  logic [1:0]        byte_cnt;
  logic [23:0]       asm_data;
  logic [ADDR_W:0]   word_next;

  // One bit wider than word_cnt so a full-depth load ends without wrapping.
  assign word_next = {1'b0, word_cnt} + (ADDR_W + 1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      len        <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      asm_data   <= '0;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (len_words > DEPTH_L) begin
              err <= 1'b1;
            end else if (len_words == '0) begin
              err        <= 1'b0;
              done       <= 1'b1;
              core_rst_n <= 1'b1;
              busy       <= 1'b0;
              state      <= DONE;
            end else begin
              len        <= len_words;
              word_cnt   <= '0;
              byte_cnt   <= '0;
              err        <= 1'b0;
              core_rst_n <= 1'b0;
              done       <= 1'b0;
              busy       <= 1'b1;
              byte_ready <= 1'b1;
              state      <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (byte_valid && byte_ready) begin
            byte_cnt <= byte_cnt + 2'd1;
            // The last byte goes straight into wr_data so it only changes on a write.
            case (byte_cnt)
              2'd0: asm_data[7:0]   <= byte_data;
              2'd1: asm_data[15:8]  <= byte_data;
              2'd2: asm_data[23:16] <= byte_data;
              default: begin
                wr_data    <= {byte_data, asm_data};
                wr_addr    <= word_cnt;
                wr_en      <= 1'b1;
                byte_ready <= 1'b0;
                state      <= WRITE;
              end
            endcase
          end
        end
        WRITE: begin
          if (word_next == len) begin
            done       <= 1'b1;
            core_rst_n <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end else begin
            word_cnt   <= word_cnt + 1'b1;
            byte_ready <= 1'b1;
            state      <= COLLECT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are derived from the byte stream
// and queued at stimulus time; a negedge monitor pops and compares every memory write.
`timescale 1ns/1ps
module tb_imem_boot_loader;
  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [10:0] len_words = '0;
  logic        byte_valid = 0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, wr_en, core_rst_n, busy, done, err;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    bit          last;
  } exp_t;
  exp_t sb[$];
  bit   pend_last = 0;

  imem_boot_loader #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .len_words(len_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pend_last) begin
        check("done_after_last_write", 32'(done), 32'd1);
        check("core_run_after_last_write", 32'(core_rst_n), 32'd1);
        pend_last = 0;
      end
      if (wr_en === 1'b1) begin
        check("byte_ready_in_write", 32'(byte_ready), 32'd0);
        check("core_held_in_write", 32'(core_rst_n), 32'd0);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr=%0d data=0x%08h, expected no write", wr_addr, wr_data);
        end else begin
          e = sb.pop_front();
          $display("[TB] write addr=%0d data=0x%08h", wr_addr, wr_data);
          check("wr_addr", 32'(wr_addr), 32'(e.addr));
          check("wr_data", wr_data, e.data);
          pend_last = e.last;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, wr_data, 32'd0);
    check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Leaves the bench aligned one step after a rising edge.
  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int len);
    start = 1;
    len_words = 11'(len);
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc = 0;
    int n = 0;
    byte_valid = 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    byte_valid = 1;
    byte_data = b;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = byte_ready;
      @(posedge clk);
      #1;
      n++;
    end
    byte_valid = 0;
    check("byte_accepted_in_time", 32'(acc), 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", 32'(done), 32'd1);
    check("core_running", 32'(core_rst_n), 32'd1);
    check("idle_after_load", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // mode: 0 back-to-back, 1 one idle cycle before each byte, 2 random gaps.
  task automatic run_load(input int len, input logic [7:0] bytes[$], input int mode, input bit inj);
    exp_t e;
    int   gap;
    for (int w = 0; w < len; w++) begin
      e.addr = 10'(w);
      e.data = 32'(bytes[4*w]) + 32'(bytes[4*w+1]) * 256 +
               32'(bytes[4*w+2]) * 65536 + 32'(bytes[4*w+3]) * 16777216;
      e.last = (w == len - 1);
      sb.push_back(e);
    end
    $display("[TB] load len=%0d mode=%0d inject=%0d", len, mode, inj);
    pulse_start(len);
    @(negedge clk);
    check("busy_after_start", 32'(busy), 32'd1);
    check("core_held_after_start", 32'(core_rst_n), 32'd0);
    check("done_low_after_start", 32'(done), 32'd0);
    check("err_low_after_start", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < bytes.size(); i++) begin
      if (inj && i == 2) pulse_start(1);
      if (inj && i == 6) pulse_start(1025);
      gap = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      send_byte(bytes[i], gap);
    end
    wait_done();
  endtask

  initial begin
    logic [7:0] prog[$];
    logic [7:0] rnd[$];
    int len;

    prog = '{8'h93, 8'h01, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
             8'h13, 8'h01, 8'h50, 8'h00};

    // 1: reset values, then a back-to-back 3-word load.
    rst = 1;
    #3;
    check_reset_vals("reset");
    do_reset();
    check_reset_vals("after_reset");
    run_load(3, prog, 0, 0);

    // 2: same program with byte_valid toggling.
    run_load(3, prog, 1, 0);

    // 3: zero-length load.
    do_reset();
    pulse_start(0);
    @(negedge clk);
    check("len0_done", 32'(done), 32'd1);
    check("len0_core_run", 32'(core_rst_n), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // 4: oversize length flags err and stays idle; a legal start clears it.
    do_reset();
    pulse_start(1025);
    @(negedge clk);
    check("oversize_err", 32'(err), 32'd1);
    check("oversize_busy", 32'(busy), 32'd0);
    check("oversize_done", 32'(done), 32'd0);
    check("oversize_core_held", 32'(core_rst_n), 32'd0);
    repeat (3) @(negedge clk);
    check("oversize_no_ready", 32'(byte_ready), 32'd0);
    @(posedge clk);
    #1;
    rnd = '{};
    for (int i = 0; i < 4; i++) rnd.push_back(8'($urandom));
    run_load(1, rnd, 0, 0);

    // 5: asynchronous reset in the middle of word 0, then reload.
    $display("[TB] reset mid-load");
    pulse_start(1);
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    rst = 1;
    #2;
    check_reset_vals("midload_reset");
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    run_load(1, '{8'h6F, 8'h00, 8'h80, 8'h00}, 0, 0);

    // 6: starts while busy are ignored; restart from DONE reloads from address 0.
    rnd = '{};
    for (int i = 0; i < 12; i++) rnd.push_back(8'($urandom));
    run_load(3, rnd, 0, 1);
    check("err_after_ignored_start", 32'(err), 32'd0);
    rnd = '{};
    for (int i = 0; i < 8; i++) rnd.push_back(8'($urandom));
    run_load(2, rnd, 0, 0);

    // Randomised loads.
    for (int t = 0; t < 6; t++) begin
      len = int'($urandom_range(1, 6));
      rnd = '{};
      for (int i = 0; i < 4 * len; i++) rnd.push_back(8'($urandom));
      run_load(len, rnd, 2, 0);
    end

    // Full-depth load: last write lands at address 1023.
    rnd = '{};
    for (int i = 0; i < 4096; i++) rnd.push_back(8'($urandom));
    run_load(1024, rnd, 0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
